key_debounce_pulse: RTL and testbench

Conditions one raw DE2 pushbutton into the single-cycle `next` strobe used by the LED-selection stage. That stage advances its 3-bit select on each `next` edge.
- Synchronises the asynchronous key to `clk` and rejects contact bounce.
- Emits exactly one clean one-`clk` pulse per debounced press.
- Optionally auto-repeats while the key is held.
- Sits directly upstream of the LED blink/demux block; `next_pulse` drives its `next` input.

---
 rtl/key_debounce_pulse.sv | 136 +++++++++++++
 tb/tb_key_debounce_pulse.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce FSM and optional auto-repeat,
// producing a one-cycle next_pulse strobe for the LED-selection stage.
module key_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_raw,
    output logic       next_pulse,
    output logic       key_held,
    output logic       repeat_active,
    output logic [2:0] state_dbg
);

    localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int          CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CHK = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        REL_CHK   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             s1_q, s1_d, s2_q, s2_d;
    logic             next_pulse_q, next_pulse_d;
    logic             key_held_q, key_held_d;
    logic             repeat_active_q, repeat_active_d;
    logic             pressed;
    logic             pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q            <= KEY_ACTIVE_LOW;
            s2_q            <= KEY_ACTIVE_LOW;
            state_q         <= IDLE;
            cnt_q           <= '0;
            next_pulse_q    <= 1'b0;
            key_held_q      <= 1'b0;
            repeat_active_q <= 1'b0;
        end else begin
            s1_q            <= s1_d;
            s2_q            <= s2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            next_pulse_q    <= next_pulse_d;
            key_held_q      <= key_held_d;
            repeat_active_q <= repeat_active_d;
        end
    end

    always_comb begin
        s1_d    = key_raw;
        s2_d    = s1_q;
        pressed = s2_q ^ KEY_ACTIVE_LOW;

        // Counter saturates so a long hold with repeat disabled cannot wrap.
        cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_inc;
        pulse   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pressed) state_d = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse   = 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end else if (REPEAT_EN && (cnt_q == DLY_LAST)) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    pulse   = 1'b1;
                end
            end
            REPEAT: begin
                if (!pressed) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    pulse = 1'b1;
                end
            end
            REL_CHK: begin
                // A re-press while releasing returns to HELD without a new pulse.
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        next_pulse_d    = pulse & ~next_pulse_q;
        key_held_d      = (state_d == HELD) || (state_d == REPEAT) || (state_d == REL_CHK);
        repeat_active_d = (state_d == REPEAT);
    end

    assign next_pulse    = next_pulse_q;
    assign key_held      = key_held_q;
    assign repeat_active = repeat_active_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: expected pulse cycles are queued as keys are driven
// and matched against next_pulse by a negedge monitor.
module tb_key_debounce_pulse;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_raw;
    logic       key_raw_b;
    logic       next_pulse, key_held, repeat_active;
    logic       next_pulse_b, key_held_b, repeat_active_b;
    logic [2:0] state_dbg, state_dbg_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_b_q[$];

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8), .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
        .next_pulse(next_pulse), .key_held(key_held),
        .repeat_active(repeat_active), .state_dbg(state_dbg)
    );

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8), .KEY_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw_b),
        .next_pulse(next_pulse_b), .key_held(key_held_b),
        .repeat_active(repeat_active_b), .state_dbg(state_dbg_b)
    );

    // Clock and cycle index (cyc == N at the negedge following rising edge N).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard: every pulse must match the head of its expected queue.
    always @(negedge clk) begin
        if (next_pulse === 1'b1) begin
            if (exp_q.size() == 0) check("pulse_unexpected", 32'(next_pulse), 32'd0);
            else                   check("pulse_cycle", cyc, exp_q.pop_front());
        end
        if (next_pulse_b === 1'b1) begin
            if (exp_b_q.size() == 0) check("pulse_b_unexpected", 32'(next_pulse_b), 32'd0);
            else                     check("pulse_b_cycle", cyc, exp_b_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t, p, r;
        reset_n   = 1'b0;
        key_raw   = 1'b1;
        key_raw_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_next_pulse", 32'(next_pulse), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        check("rst_repeat_active", 32'(repeat_active), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_b_key_held", 32'(key_held_b), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press held 10 cycles: one pulse 7 edges after the first pressed sample.
        t = cyc;
        key_raw = 1'b0;
        exp_q.push_back(t + 7);
        wait_until(t + 6);  check("clean_held_pre", 32'(key_held), 32'd0);
        wait_until(t + 7);  check("clean_held_at_pulse", 32'(key_held), 32'd1);
        wait_until(t + 10); key_raw = 1'b1;
        wait_until(t + 16); check("clean_held_releasing", 32'(key_held), 32'd1);
        wait_until(t + 17); check("clean_held_released", 32'(key_held), 32'd0);
        check("clean_state_idle", 32'(state_dbg), 32'd0);
        wait_until(t + 22); check("clean_missing", 32'(exp_q.size()), 32'd0);

        // Bounce: 2-cycle toggles for 12 cycles, then stable press.
        t = cyc;
        for (int i = 0; i < 6; i++) begin
            key_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_until(t + 2 * (i + 1));
        end
        key_raw = 1'b0;
        exp_q.push_back(t + 12 + 7);
        wait_until(t + 12); check("bounce_no_accept", 32'(key_held), 32'd0);
        wait_until(t + 18); check("bounce_held_pre", 32'(key_held), 32'd0);
        wait_until(t + 19); check("bounce_held", 32'(key_held), 32'd1);
        wait_until(t + 24); key_raw = 1'b1;
        wait_until(t + 34); check("bounce_missing", 32'(exp_q.size()), 32'd0);

        // Auto-repeat: pulses at +0, +20, +28, +36, +44, +52 from acceptance.
        t = cyc;
        key_raw = 1'b0;
        p = t + 7;
        exp_q.push_back(p);
        exp_q.push_back(p + 20);
        for (int k = 1; k <= 4; k++) exp_q.push_back(p + 20 + 8 * k);
        wait_until(p + 19); check("rep_active_pre", 32'(repeat_active), 32'd0);
        wait_until(p + 20); check("rep_active_on", 32'(repeat_active), 32'd1);
        wait_until(p + 55); key_raw = 1'b1;
        wait_until(p + 57); check("rep_active_hold", 32'(repeat_active), 32'd1);
        wait_until(p + 58); check("rep_active_off", 32'(repeat_active), 32'd0);
        check("rep_held_releasing", 32'(key_held), 32'd1);
        wait_until(p + 62); check("rep_held_released", 32'(key_held), 32'd0);
        wait_until(p + 66); check("rep_missing", 32'(exp_q.size()), 32'd0);

        // Release bounce: one-cycle re-press glitch during release, no extra pulse.
        t = cyc;
        key_raw = 1'b0;
        p = t + 7;
        exp_q.push_back(p);
        wait_until(p + 5);  r = cyc; key_raw = 1'b1;
        wait_until(r + 2);  key_raw = 1'b0;
        wait_until(r + 3);  key_raw = 1'b1;
        wait_until(r + 5);  check("relb_held_glitch", 32'(key_held), 32'd1);
        wait_until(r + 9);  check("relb_held_pre", 32'(key_held), 32'd1);
        wait_until(r + 10); check("relb_held_fall", 32'(key_held), 32'd0);
        wait_until(r + 14); check("relb_missing", 32'(exp_q.size()), 32'd0);

        // Release glitch while held: repeat delay restarts from the re-press.
        t = cyc;
        key_raw = 1'b0;
        p = t + 7;
        exp_q.push_back(p);
        wait_until(p + 10); r = cyc; key_raw = 1'b1;
        wait_until(r + 1);  key_raw = 1'b0;
        exp_q.push_back(r + 24);
        wait_until(r + 23); check("restart_active_pre", 32'(repeat_active), 32'd0);
        wait_until(r + 24); check("restart_active_on", 32'(repeat_active), 32'd1);
        wait_until(r + 26); key_raw = 1'b1;
        wait_until(r + 36); check("restart_held_off", 32'(key_held), 32'd0);
        check("restart_missing", 32'(exp_q.size()), 32'd0);

        // REPEAT_EN=0 instance: 100-cycle hold yields exactly one pulse.
        t = cyc;
        key_raw_b = 1'b0;
        exp_b_q.push_back(t + 7);
        wait_until(t + 30);  check("norep_active_30", 32'(repeat_active_b), 32'd0);
        wait_until(t + 50);  check("norep_held_50", 32'(key_held_b), 32'd1);
        wait_until(t + 90);  check("norep_active_90", 32'(repeat_active_b), 32'd0);
        wait_until(t + 100); key_raw_b = 1'b1;
        wait_until(t + 110); check("norep_held_off", 32'(key_held_b), 32'd0);
        check("norep_missing", 32'(exp_b_q.size()), 32'd0);

        // Reset during a repeat pulse with the key still pressed.
        t = cyc;
        key_raw = 1'b0;
        p = t + 7;
        exp_q.push_back(p);
        exp_q.push_back(p + 20);
        exp_q.push_back(p + 28);
        wait_until(p + 28);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_next_pulse", 32'(next_pulse), 32'd0);
        check("rstmid_key_held", 32'(key_held), 32'd0);
        check("rstmid_repeat_active", 32'(repeat_active), 32'd0);
        check("rstmid_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(p + 36);
        wait_until(p + 35); check("rstmid_held_pre", 32'(key_held), 32'd0);
        wait_until(p + 36); check("rstmid_held_new", 32'(key_held), 32'd1);
        wait_until(p + 40); key_raw = 1'b1;
        wait_until(p + 52); check("rstmid_held_off", 32'(key_held), 32'd0);
        check("rstmid_missing", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
